keypad_event_gen: RTL and testbench

//  Upstream stage of the keypad-driven VGA cursor FSM: turns 8 raw, bouncy, asynchronous

---
 rtl/keypad_pkg.sv | 34 +++
 rtl/key_debounce.sv | 45 ++++
 rtl/keypad_event_gen.sv | 93 +++++++++
 tb/tb_keypad_event_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, FSM encoding and helpers for the keypad event path.
package keypad_pkg;

  // Bit positions of the direction keys as the cursor FSM consumes them.
  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_UP    = 3;

  localparam int NUM_KEYS = 8;

  // Default timing, all in ticks of the shared free-running timer.
  localparam logic [31:0] DEF_DEBOUNCE_TICKS = 32'd20;
  localparam logic [31:0] DEF_REPEAT_DELAY   = 32'd250;
  localparam logic [31:0] DEF_REPEAT_RATE    = 32'd100;

  // Event FSM encoding.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Index of the lowest set bit; returns 0 for an all-zero vector.
  function automatic logic [2:0] lowest_set(input logic [NUM_KEYS-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-FF synchronizer followed by a timer-based debounce.
// The synchronized level is accepted once it has stayed unchanged for
// DEBOUNCE_TICKS timer ticks; elapsed time uses wrapping 32-bit subtraction.
module key_debounce
  import keypad_pkg::*;
#(
  parameter logic [31:0] DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] timer,
  input  logic        raw,
  output logic        stable
);

  logic        sync_1;
  logic        sync_2;
  logic        sync_prev;
  logic [31:0] stamp;
  logic [31:0] elapsed;

  // Wrapping difference keeps a timer rollover invisible to the window check.
  assign elapsed = timer - stamp;

  // Synchronize, restart the window on every change, accept a quiet level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
      stamp     <= 32'd0;
      stable    <= 1'b0;
    end else begin
      sync_1    <= raw;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      if (sync_2 != sync_prev) begin
        stamp <= timer;
      end else if ((sync_2 != stable) && (elapsed >= DEBOUNCE_TICKS)) begin
        stable <= sync_2;
      end
    end
  end

endmodule

// File: rtl/keypad_event_gen.sv
// Turns 8 raw button pins into debounced levels (key_held) and one-hot,
// single-cycle key events (keypad) with optional auto-repeat.
// Strobe protocol: keypad carries at most one set bit and is high for exactly
// one clk; there is no back-pressure, the consumer must take it that cycle.
// state_dbg exposes the event FSM state for checkers.
module keypad_event_gen
  import keypad_pkg::*;
#(
  parameter logic [31:0] DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter logic        REPEAT_EN      = 1'b1,
  parameter logic [31:0] REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter logic [31:0] REPEAT_RATE    = DEF_REPEAT_RATE,
  parameter logic        ACTIVE_LOW     = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         timer,
  input  logic [NUM_KEYS-1:0] raw_keys,
  output logic [NUM_KEYS-1:0] keypad,
  output logic [NUM_KEYS-1:0] key_held,
  output state_t              state_dbg
);

  logic [NUM_KEYS-1:0] keys_in;
  state_t              state;
  logic [2:0]          act;
  logic                rep;
  logic [31:0]         t0;
  logic [31:0]         elapsed;
  logic [31:0]         repeat_limit;

  // Normalize polarity so "pressed" is always 1 from here on.
  assign keys_in = raw_keys ^ {NUM_KEYS{ACTIVE_LOW}};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_deb
    key_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .timer (timer),
      .raw   (keys_in[i]),
      .stable(key_held[i])
    );
  end

  // First repeat waits the longer delay, later repeats use the rate.
  assign elapsed      = timer - t0;
  assign repeat_limit = rep ? REPEAT_RATE : REPEAT_DELAY;
  assign state_dbg    = state;

  // Event FSM: pick the lowest held key, strobe it, then hold off until
  // release or the next repeat point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      act    <= 3'd0;
      rep    <= 1'b0;
      t0     <= 32'd0;
      keypad <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          keypad <= '0;
          if (|key_held) begin
            act   <= lowest_set(key_held);
            rep   <= 1'b0;
            state <= S_FIRE;
          end
        end
        S_FIRE: begin
          keypad <= NUM_KEYS'(1) << act;
          t0     <= timer;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          keypad <= '0;
          if (!key_held[act]) begin
            state <= S_IDLE;
          end else if (REPEAT_EN && (elapsed >= repeat_limit)) begin
            rep   <= 1'b1;
            state <= S_FIRE;
          end
        end
        default: begin
          keypad <= '0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_event_gen.sv
// Directed bench for keypad_event_gen: a behavioural model is checked every
// cycle, and hand-computed latencies/counts pin the model and the DUT.
module tb_keypad_event_gen;
  import keypad_pkg::*;

  localparam logic [31:0] DEB   = 32'd20;
  localparam logic [31:0] DELAY = 32'd250;
  localparam logic [31:0] RATE  = 32'd100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] timer;
  logic [7:0]  raw_keys;
  logic [7:0]  keypad, key_held;
  logic [7:0]  keypad_nr, key_held_nr;
  state_t      state_dbg, state_nr;

  keypad_event_gen #(
    .DEBOUNCE_TICKS(DEB), .REPEAT_EN(1'b1), .REPEAT_DELAY(DELAY),
    .REPEAT_RATE(RATE), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .timer(timer), .raw_keys(raw_keys),
    .keypad(keypad), .key_held(key_held), .state_dbg(state_dbg)
  );

  keypad_event_gen #(
    .DEBOUNCE_TICKS(DEB), .REPEAT_EN(1'b0), .REPEAT_DELAY(DELAY),
    .REPEAT_RATE(RATE), .ACTIVE_LOW(1'b0)
  ) dut_nr (
    .clk(clk), .rst(rst), .timer(timer), .raw_keys(raw_keys),
    .keypad(keypad_nr), .key_held(key_held_nr), .state_dbg(state_nr)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int nr_cnt   = 0;

  // ---------------- behavioural model ----------------
  // Synchronized view of each pin is the pin two edges ago. A key's level is
  // accepted once that view has shown the same value for DEB ticks, counted
  // from the timer at the edge where the value first appeared.
  logic [7:0]  m_h1, m_h2, m_run, m_held, m_keypad;
  logic [31:0] m_run_t [8];
  int          m_act;
  bit          m_pending, m_waiting, m_rep;
  logic [31:0] m_tlast;

  function automatic int lowest_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_h1 = '0; m_h2 = '0; m_run = '0; m_held = '0; m_keypad = '0;
    for (int k = 0; k < 8; k++) m_run_t[k] = '0;
    m_act = 0; m_pending = 0; m_waiting = 0; m_rep = 0; m_tlast = '0;
  endtask

  // Advance the model by one clock edge using the inputs the edge will sample.
  task automatic model_step();
    logic [7:0] s;
    if (rst) begin
      model_reset();
      return;
    end
    // Event generation sees the accepted levels from before this edge.
    m_keypad = 8'h00;
    if (m_pending) begin
      m_keypad  = 8'h01 << m_act;
      m_tlast   = timer;
      m_pending = 0;
      m_waiting = 1;
    end else if (!m_waiting) begin
      if (m_held != 8'h00) begin
        m_act     = lowest_idx(m_held);
        m_rep     = 0;
        m_pending = 1;
      end
    end else if (!m_held[m_act]) begin
      m_waiting = 0;
    end else if ((timer - m_tlast) >= (m_rep ? RATE : DELAY)) begin
      m_rep     = 1;
      m_pending = 1;
    end
    // Debounce.
    s    = m_h2;
    m_h2 = m_h1;
    m_h1 = raw_keys;
    for (int k = 0; k < 8; k++) begin
      if (s[k] != m_run[k]) begin
        m_run[k]   = s[k];
        m_run_t[k] = timer;
      end else if ((m_run[k] != m_held[k]) && ((timer - m_run_t[k]) >= DEB)) begin
        m_held[k] = m_run[k];
      end
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check8("cyc_keypad", keypad, m_keypad);
      check8("cyc_key_held", key_held, m_held);
      check8("cyc_key_held_nr", key_held_nr, m_held);
    end
  end

  always @(negedge clk) begin
    if (keypad_nr != 8'h00) nr_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #2;
    model_step();
    @(posedge clk);
    #1;
    timer = timer + 32'd1;
  endtask

  task automatic run_count(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (keypad != 8'h00) cnt++;
    end
  endtask

  task automatic expect_strobe(input string name, input int exp_n,
                               input logic [7:0] exp_v, input int max_n);
    int n;
    logic [7:0] v;
    n = 0;
    v = 8'h00;
    while ((n < max_n) && (v == 8'h00)) begin
      step();
      n++;
      if (keypad != 8'h00) v = keypad;
    end
    check_int({name, "_latency"}, n, exp_n);
    check8({name, "_value"}, v, exp_v);
  endtask

  task automatic settle();
    int c;
    raw_keys = 8'h00;
    run_count(40, c);
  endtask

  // ---------------- stimulus ----------------
  int c;
  int offs[$];
  int exp_offs[4] = '{251, 352, 453, 554};

  initial begin
    rst      = 1'b1;
    timer    = 32'd0;
    raw_keys = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check8("reset_keypad", keypad, 8'h00);
    check8("reset_key_held", key_held, 8'h00);
    check_int("reset_state", int'(state_dbg), int'(S_IDLE));
    check_int("reset_state_nr", int'(state_nr), int'(S_IDLE));
    rst    = 1'b0;
    chk_en = 1'b1;

    // 1: single key, no repeat before the delay.
    raw_keys = 8'h01;
    expect_strobe("single", 25, 8'h01, 40);
    check8("model_pin_single", m_keypad, 8'h01);
    check8("single_held", key_held, 8'h01);
    run_count(240, c);
    check_int("single_no_early_repeat", c, 0);
    settle();
    check8("single_released", key_held, 8'h00);

    // 2: bounce on bit 2, then a steady press.
    c = 0;
    for (int seg = 0; seg < 12; seg++) begin
      int cs;
      raw_keys = (seg % 2 == 0) ? 8'h04 : 8'h00;
      run_count(5, cs);
      c += cs;
    end
    check_int("bounce_no_strobe", c, 0);
    check8("bounce_held", key_held, 8'h00);
    raw_keys = 8'h04;
    expect_strobe("bounce_settle", 25, 8'h04, 40);
    settle();

    // 3: hold bit 3, auto-repeat, and the non-repeating instance.
    nr_cnt   = 0;
    raw_keys = 8'h08;
    expect_strobe("repeat_first", 25, 8'h08, 40);
    offs.delete();
    for (int i = 1; i <= 600; i++) begin
      step();
      if (keypad != 8'h00) begin
        offs.push_back(i);
        check8("repeat_value", keypad, 8'h08);
      end
    end
    check_int("repeat_count", offs.size(), 4);
    for (int j = 0; j < 4; j++)
      check_int("repeat_offset", (j < offs.size()) ? offs[j] : -1, exp_offs[j]);
    raw_keys = 8'h00;
    run_count(100, c);
    check_int("repeat_after_release", c, 0);
    check_int("norepeat_count", nr_cnt, 1);
    settle();

    // 4: two keys together, lowest wins; the other fires after release.
    raw_keys = 8'h06;
    expect_strobe("pair_first", 25, 8'h02, 40);
    run_count(50, c);
    check_int("pair_hold_quiet", c, 0);
    raw_keys = 8'h04;
    expect_strobe("pair_second", 26, 8'h04, 60);
    settle();

    // 5: debounce window spanning the timer wrap.
    timer    = 32'hFFFF_FFF0;
    raw_keys = 8'h01;
    expect_strobe("wrap", 25, 8'h01, 40);
    check8("model_pin_wrap", m_keypad, 8'h01);

    // 6: asynchronous reset while holding, right on a strobe cycle.
    rst = 1'b1;
    #1;
    check8("async_keypad", keypad, 8'h00);
    check8("async_key_held", key_held, 8'h00);
    check_int("async_state", int'(state_dbg), int'(S_IDLE));
    model_reset();
    run_count(3, c);
    check_int("in_reset_quiet", c, 0);
    rst = 1'b0;
    expect_strobe("post_reset", 25, 8'h01, 40);
    raw_keys = 8'h00;
    run_count(60, c);
    check_int("post_reset_release_quiet", c, 0);
    check8("final_held", key_held, 8'h00);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
